ref_bank_loader: RTL and testbench
==================================

Name: ref_bank_loader

Overview:
Upstream write stage for the ping-pong reference Bank pair in the ME_DMT search-window buffer. It accepts 8-pixel reference words over a valid/ready stream and generates the Bank write side: data, write_address 0..DEPTH-1 and Bank_sel. It fills one bank, marks it full and switches to the other. It stalls when both banks are full, until the downstream ME reader releases one.

Parameters:
PIXEL, 8, bits per pixel
LANE, 8, pixels per word (word width = LANE*PIXEL = 64)
DEPTH, 96, words per bank (search-window rows)
ADDR_W, 7, bank address width (must satisfy 2^ADDR_W >= DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  sync pulse: abort any fill, clear both full flags, restart at bank 0 addr 0
in_valid  in  1  upstream word valid
in_data  in  LANE*PIXEL  upstream 8-pixel word
in_ready  out  1  loader can accept a word this cycle
bank_release  in  2  one-cycle pulse per bank from reader: bank consumed
ref_in  out  LANE*PIXEL  write data to Bank (registered)
write_address  out  ADDR_W  write address to Bank (registered)
Bank_sel  out  1  bank being written (registered), 0 or 1
wr_en  out  1  write strobe to Bank (registered)
bank_full  out  2  bit i = bank i holds a complete window

Behaviour:
- Reset (rst_n=0, async): ref_in=0, write_address=0, Bank_sel=0, wr_en=0, bank_full=2'b00, cur=0, cnt=0, state=FILL.
- Internal: cur (bank being filled), cnt (next address, 0..DEPTH-1), state in {FILL, WAIT}.
- in_ready = (state==FILL) && !bank_full[cur] && !start. This is combinational from registers and start only. It does not depend on in_valid.
- Accept = in_valid && in_ready. On accept at edge N: wr_en=1, ref_in=in_data, write_address=cnt, Bank_sel=cur, all visible after edge N. Latency is 1 cycle. With no accept, wr_en=0 and the other write outputs hold their values.
- cnt increments per accept. On the accept with cnt==DEPTH-1:
  - cnt goes to 0.
  - bank_full[cur] is set at the same edge as the final write.
  - cur toggles.
  - If bank_full[~cur] is 1 after that edge's release processing, state goes to WAIT; otherwise it stays FILL.
- WAIT: in_ready=0. The state returns to FILL on the edge where bank_full[cur] becomes 0, so in_ready=1 on the following cycle.
- Release: a bank_release[i] pulse clears bank_full[i] at the next edge.
  - A pulse for a bank that is not full is ignored.
  - If a set and a release hit the same bank in the same cycle, the set wins. The release targets a non-full bank, so it is ignored.
  - Releases of both banks in the same cycle are allowed.
- start: at the next edge, cnt=0, cur=0, bank_full=00, state=FILL, wr_en=0. start overrides a same-cycle accept and release. Words already written stay in the Bank but are treated as invalid.
- Backpressure bubbles (in_valid=0) insert no writes and do not advance cnt.
- Reset mid-fill: everything returns to reset values asynchronously. The fill restarts at bank 0, address 0.
- Never write a bank whose full flag is set. Never emit write_address >= DEPTH.

Decomposition:
- Shared package me_pkg holds: PIXEL, LANE, DEPTH, ADDR_W, the word-width constant, and the state typedef {FILL, WAIT}. The Bank and the reader use the same package.
- No sub-module is needed. The counter, flags and FSM fit in one module of about 150 lines.

Test Plan:
- Fill bank 0: after reset, in_valid=1 continuously with data {8{k}} for k=0..95.
  - Required: wr_en=1 for 96 cycles, write_address 0..95, Bank_sel=0, ref_in={8{k}} one cycle after each accept.
  - bank_full=01 after word 95, Bank_sel=1 for the next word.
- Double full stall: continue 96 more words with no release.
  - Required: bank 1 fills at addresses 0..95, bank_full=11, state WAIT, in_ready=0.
  - Word 192 is held; wr_en stays 0.
- Release resume: from the double-full stall, pulse bank_release=01.
  - Required: bank_full=10 next edge, in_ready=1 the following cycle, next write goes to Bank_sel=0, write_address=0.
- Bubbles and a spurious release: toggle in_valid 1/0 every cycle during a fill, and pulse bank_release=10 while bank 1 is not full.
  - Required: addresses contiguous with no skips, bank_full unchanged by the spurious pulse.
- start mid-fill: at cnt=40 in bank 1 (bank_full=01), assert start together with in_valid.
  - Required: no write that cycle, bank_full=00.
  - Next accepted word goes to Bank_sel=0, write_address=0.
- Async reset mid-fill: drop rst_n between clock edges at cnt=50.
  - Required: wr_en, bank_full, write_address and Bank_sel go to 0 immediately, without waiting for a clock edge.
  - After release of reset, the first write goes to address 0.

Source files
------------

// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module      : me_pkg
// Description : Shared constants and types for the ME_DMT search-window
//               reference Bank path (loader, Bank, reader).
//               PIXEL  - bits per pixel
//               LANE   - pixels per reference word
//               DEPTH  - words per bank (search-window rows)
//               ADDR_W - bank address width, 2**ADDR_W >= DEPTH
//               WORD_W - reference word width in bits
// Revision    : 1.0 - initial release
// ============================================================================
package me_pkg;

  localparam int PIXEL  = 8;
  localparam int LANE   = 8;
  localparam int DEPTH  = 96;
  localparam int ADDR_W = 7;
  localparam int WORD_W = LANE * PIXEL;

  // Loader fill state: FILL accepts words, WAIT parks while the bank that
  // would be written next still holds an unconsumed window.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    WAIT = 1'b1
  } fill_state_e;

endpackage : me_pkg
`default_nettype wire

// File: rtl/ref_bank_loader.sv
`default_nettype none
// ============================================================================
// Module      : ref_bank_loader
// Description : Write stage for the ping-pong reference Bank pair. Accepts
//               LANE-pixel words on a valid/ready stream and produces the
//               registered Bank write side (data, address, bank select,
//               strobe). Fills one bank, flags it full, switches to the other,
//               and stalls while the target bank is still full.
// Ports       : clk           - system clock, rising edge
//               rst_n         - asynchronous active-low reset
//               start         - sync pulse: abort fill, clear flags, restart
//               in_valid      - upstream word valid
//               in_data       - upstream word (WORD_W bits)
//               in_ready      - loader accepts a word this cycle
//               bank_release  - per-bank one-cycle "consumed" pulse
//               ref_in        - Bank write data (registered)
//               write_address - Bank write address (registered)
//               Bank_sel      - bank being written (registered)
//               wr_en         - Bank write strobe (registered)
//               bank_full     - bit i set while bank i holds a full window
// Revision    : 1.0 - initial release
// ============================================================================
module ref_bank_loader
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic [1:0]        bank_release,
  output logic [WORD_W-1:0] ref_in,
  output logic [ADDR_W-1:0] write_address,
  output logic              Bank_sel,
  output logic              wr_en,
  output logic [1:0]        bank_full
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Fill-control state
  fill_state_e       r_state, w_state_nxt;
  logic              r_cur,   w_cur_nxt;
  logic [ADDR_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]        r_full,  w_full_nxt;

  // Registered Bank write side
  logic [WORD_W-1:0] r_ref_in;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sel;
  logic              r_wr_en;

  logic w_in_ready;
  logic w_accept;
  logic w_last;

  assign w_in_ready = (r_state == FILL) && !r_full[r_cur] && !start;
  assign w_accept   = in_valid && w_in_ready;
  assign w_last     = (r_cnt == c_LAST_ADDR);

  always_comb begin
    // Releases only clear bits that are set, so a pulse for an empty bank
    // falls out as a no-op. A same-cycle set is applied afterwards and wins.
    w_full_nxt  = r_full & ~bank_release;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_state_nxt = r_state;

    if (start) begin
      w_full_nxt  = 2'b00;
      w_cnt_nxt   = '0;
      w_cur_nxt   = 1'b0;
      w_state_nxt = FILL;
    end else if (w_accept) begin
      if (w_last) begin
        w_full_nxt[r_cur] = 1'b1;
        w_cnt_nxt         = '0;
        w_cur_nxt         = ~r_cur;
        // Park if the bank we are switching to is still full after this
        // edge's releases have been applied.
        w_state_nxt       = w_full_nxt[~r_cur] ? WAIT : FILL;
      end else begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
      end
    end else if ((r_state == WAIT) && !w_full_nxt[r_cur]) begin
      w_state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cur   <= 1'b0;
      r_cnt   <= '0;
      r_full  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_full_nxt;
    end
  end

  // Write data/address/select hold their last values between writes; only
  // the strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_in <= '0;
      r_addr   <= '0;
      r_sel    <= 1'b0;
      r_wr_en  <= 1'b0;
    end else if (w_accept) begin
      r_ref_in <= in_data;
      r_addr   <= r_cnt;
      r_sel    <= r_cur;
      r_wr_en  <= 1'b1;
    end else begin
      r_wr_en  <= 1'b0;
    end
  end

  assign in_ready      = w_in_ready;
  assign ref_in        = r_ref_in;
  assign write_address = r_addr;
  assign Bank_sel      = r_sel;
  assign wr_en         = r_wr_en;
  assign bank_full     = r_full;

endmodule : ref_bank_loader
`default_nettype wire

// File: tb/tb_ref_bank_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ref_bank_loader
// Description : Self-checking bench for ref_bank_loader. Expected Bank writes
//               are queued when a word is offered and compared when wr_en
//               appears; flags and ready are checked at fixed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ref_bank_loader;
  import me_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic [1:0]        bank_release;
  logic [WORD_W-1:0] ref_in;
  logic [ADDR_W-1:0] write_address;
  logic              Bank_sel;
  logic              wr_en;
  logic [1:0]        bank_full;

  ref_bank_loader u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .bank_release  (bank_release),
    .ref_in        (ref_in),
    .write_address (write_address),
    .Bank_sel      (Bank_sel),
    .wr_en         (wr_en),
    .bank_full     (bank_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } exp_wr_t;

  typedef struct {
    logic       vld;
    logic [1:0] rel;
    logic       exp_ready;
    logic [1:0] exp_full;
  } vec_t;

  exp_wr_t sb[$];
  vec_t    tbl[8];
  int      n_cmp = 0;
  int      n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] word_of(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {LANE{b}};
  endfunction

  // Scoreboard consumer: every strobe must match the oldest queued write.
  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(write_address), 64'hFFFF);
      end else begin
        exp_wr_t e;
        e = sb.pop_front();
        chk("wr_bank", 64'(Bank_sel), 64'(e.bank));
        chk("wr_addr", 64'(write_address), 64'(e.addr));
        chk("wr_data", ref_in, e.data);
      end
    end
  end

  // Called right after a falling edge; returns after the next falling edge.
  task automatic send_word(input logic [WORD_W-1:0] d, input logic b, input int a);
    in_valid     = 1'b1;
    in_data      = d;
    bank_release = 2'b00;
    start        = 1'b0;
    #1;
    chk("in_ready_on_offer", 64'(in_ready), 64'd1);
    sb.push_back('{b, ADDR_W'(a), d});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill(input logic b, input int from, input int upto);
    for (int k = from; k <= upto; k++) send_word(word_of(k), b, k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;

    // Bank 1 opening with bubbles and spurious releases of the non-full bank.
    tbl[0] = '{1'b1, 2'b00, 1'b1, 2'b01};
    tbl[1] = '{1'b0, 2'b00, 1'b1, 2'b01};
    tbl[2] = '{1'b1, 2'b10, 1'b1, 2'b01};
    tbl[3] = '{1'b0, 2'b00, 1'b1, 2'b01};
    tbl[4] = '{1'b1, 2'b00, 1'b1, 2'b01};
    tbl[5] = '{1'b0, 2'b10, 1'b1, 2'b01};
    tbl[6] = '{1'b1, 2'b00, 1'b1, 2'b01};
    tbl[7] = '{1'b0, 2'b00, 1'b1, 2'b01};

    rst_n        = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    bank_release = 2'b00;
    #12;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_addr", 64'(write_address), 64'd0);
    chk("rst_sel", 64'(Bank_sel), 64'd0);
    chk("rst_ref_in", ref_in, 64'd0);
    chk("rst_full", 64'(bank_full), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Fill bank 0, then bank 1 with no release.
    fill(1'b0, 0, DEPTH - 1);
    chk("full_after_bank0", 64'(bank_full), 64'b01);
    fill(1'b1, 0, DEPTH - 1);
    chk("full_after_bank1", 64'(bank_full), 64'b11);
    chk("ready_double_full", 64'(in_ready), 64'd0);

    // Word 192 is offered but must be held.
    in_valid = 1'b1;
    in_data  = word_of(192);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_wr_en", 64'(wr_en), 64'd0);
    end

    // Release bank 0: flag clears next edge, ready the cycle after.
    bank_release = 2'b01;
    #1;
    chk("ready_during_release", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bank_release = 2'b00;
    chk("full_after_release0", 64'(bank_full), 64'b10);
    #1;
    chk("ready_after_release0", 64'(in_ready), 64'd1);
    send_word(word_of(192), 1'b0, 0);

    // Release bank 1 during an idle cycle, then finish bank 0.
    bank_release = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bank_release = 2'b00;
    chk("full_after_release1", 64'(bank_full), 64'b00);
    fill(1'b0, 1, DEPTH - 1);
    chk("full_bank0_again", 64'(bank_full), 64'b01);

    // Table-driven bubbles in bank 1.
    a = 0;
    foreach (tbl[i]) begin
      in_valid     = tbl[i].vld;
      in_data      = word_of(300 + a);
      bank_release = tbl[i].rel;
      #1;
      chk("tbl_ready", 64'(in_ready), 64'(tbl[i].exp_ready));
      if (tbl[i].vld) begin
        sb.push_back('{1'b1, ADDR_W'(a), word_of(300 + a)});
        a++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("tbl_full", 64'(bank_full), 64'(tbl[i].exp_full));
    end
    in_valid     = 1'b0;
    bank_release = 2'b00;
    chk("tbl_queue_drained", 64'(sb.size()), 64'd0);
    fill(1'b1, a, 39);

    // start with a valid word at cnt=40 in bank 1.
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = word_of(77);
    #1;
    chk("ready_during_start", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_no_write", 64'(wr_en), 64'd0);
    chk("start_full", 64'(bank_full), 64'b00);
    send_word(word_of(5), 1'b0, 0);
    fill(1'b0, 1, DEPTH - 1);
    chk("full_after_restart", 64'(bank_full), 64'b01);
    fill(1'b1, 0, 49);

    // Async reset between edges while writing bank 1 at cnt=50.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_full", 64'(bank_full), 64'd0);
    chk("arst_addr", 64'(write_address), 64'd0);
    chk("arst_sel", 64'(Bank_sel), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    send_word(word_of(9), 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("final_queue_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ref_bank_loader
`default_nettype wire
